// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: FN codes, FSM states, decoded ops
// and the bit-serial mod-3 step.
package alu_pkg;

  localparam logic [3:0] FN_PASS_A = 4'b0000;
  localparam logic [3:0] FN_PASS_B = 4'b0001;
  localparam logic [3:0] FN_ADD    = 4'b0010;
  localparam logic [3:0] FN_SUB    = 4'b0011;
  localparam logic [3:0] FN_UMOD3  = 4'b0100;
  localparam logic [3:0] FN_SADD   = 4'b1010;
  localparam logic [3:0] FN_SSUB   = 4'b1011;
  localparam logic [3:0] FN_SMOD3  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_PASS_A,
    OP_PASS_B,
    OP_ADD,
    OP_SUB,
    OP_UMOD3,
    OP_SADD,
    OP_SSUB,
    OP_SMOD3
  } op_e;

  // Unlisted codes fall back to unsigned add.
  function automatic op_e decode_fn(input logic [3:0] fn);
    op_e op;
    case (fn)
      FN_PASS_A: op = OP_PASS_A;
      FN_PASS_B: op = OP_PASS_B;
      FN_ADD:    op = OP_ADD;
      FN_SUB:    op = OP_SUB;
      FN_UMOD3:  op = OP_UMOD3;
      FN_SADD:   op = OP_SADD;
      FN_SSUB:   op = OP_SSUB;
      FN_SMOD3:  op = OP_SMOD3;
      default:   op = OP_ADD;
    endcase
    return op;
  endfunction

  // One Horner step of the remainder: (2r + bit) mod 3, r stays in 0..2.
  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    logic [2:0] v;
    v = {r, b};
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Valid/ready operand and result bus of the sequential ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       FN;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             sign;

  modport master (
    output A, B, FN, in_valid, out_ready,
    input  in_ready, out_valid, result, overflow, sign
  );

  modport slave (
    input  A, B, FN, in_valid, out_ready,
    output in_ready, out_valid, result, overflow, sign
  );

endinterface

// File: rtl/mod3_seq.sv
// Bit-serial remainder modulo 3; the MSB arrives with start, the remaining
// WIDTH-1 bits on the following cycles, done pulses once the last bit is folded in.
module mod3_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       bit_in,
  output logic       done,
  output logic [1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count;
  logic          busy;
  logic [1:0]    r;
  logic          done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      busy   <= 1'b0;
      r      <= 2'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        r     <= mod3_step(2'd0, bit_in);
        count <= CW'(1);
        busy  <= 1'b1;
      end else if (busy) begin
        r     <= mod3_step(r, bit_in);
        count <= count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          busy   <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done      = done_q;
  assign remainder = r;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/pass ops and WIDTH-cycle mod-3 ops
// behind a valid/ready handshake with registered results.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  state_e           state;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             sign_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] shreg;
  logic             mod_neg;

  op_e              op;
  logic             is_mod;
  logic             ready;
  logic             accept;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] s_val;
  logic             s_ovf;
  logic [WIDTH-1:0] neg_src;
  logic [WIDTH-1:0] neg_mag;
  logic [WIDTH-1:0] mod_src;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_sign;
  logic             m_start;
  logic             m_bit;
  logic             m_done;
  logic [1:0]       m_rem;

  assign op     = decode_fn(bus.FN);
  assign is_mod = (op == OP_UMOD3) || (op == OP_SMOD3);
  assign ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept = bus.in_valid && ready;

  assign sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff_ext = {1'b0, bus.A} - {1'b0, bus.B};
  assign s_val    = (op == OP_SSUB) ? diff_ext[WIDTH-1:0] : sum_ext[WIDTH-1:0];

  always_comb begin
    s_ovf = 1'b0;
    if (op == OP_SSUB)
      s_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (s_val[WIDTH-1] != bus.A[WIDTH-1]);
    else
      s_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (s_val[WIDTH-1] != bus.A[WIDTH-1]);
  end

  // One negator serves both signed add/sub magnitude and signed mod-3 |A|.
  assign neg_src = (op == OP_SMOD3) ? bus.A : s_val;
  assign neg_mag = neg_src[WIDTH-1] ? (~neg_src + WIDTH'(1)) : neg_src;
  assign mod_src = (op == OP_SMOD3) ? neg_mag : bus.A;

  always_comb begin
    alu_res  = sum_ext[WIDTH-1:0];
    alu_ovf  = sum_ext[WIDTH];
    alu_sign = 1'b0;
    case (op)
      OP_PASS_A: begin
        alu_res = bus.A;
        alu_ovf = 1'b0;
      end
      OP_PASS_B: begin
        alu_res = bus.B;
        alu_ovf = 1'b0;
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_ovf = diff_ext[WIDTH];
      end
      OP_SADD, OP_SSUB: begin
        alu_res  = neg_mag;
        alu_ovf  = s_ovf;
        alu_sign = s_val[WIDTH-1];
      end
      default: ;
    endcase
  end

  // The MSB is consumed on the accept edge; the shift register supplies the rest.
  assign m_start = accept && is_mod;
  assign m_bit   = (state == CALC) ? shreg[WIDTH-1] : mod_src[WIDTH-1];

  mod3_seq #(
    .WIDTH(WIDTH)
  ) u_mod3 (
    .clk      (clk),
    .reset    (reset),
    .start    (m_start),
    .bit_in   (m_bit),
    .done     (m_done),
    .remainder(m_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      shreg       <= '0;
      mod_neg     <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        CALC: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          if (m_done) begin
            result_q    <= WIDTH'(m_rem);
            overflow_q  <= 1'b0;
            sign_q      <= mod_neg && (m_rem != 2'd0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A new accept (from IDLE or a draining DONE) overrides the default moves.
      if (accept) begin
        if (is_mod) begin
          state       <= CALC;
          out_valid_q <= 1'b0;
          shreg       <= {mod_src[WIDTH-2:0], 1'b0};
          mod_neg     <= (op == OP_SMOD3) && bus.A[WIDTH-1];
        end else begin
          state       <= DONE;
          out_valid_q <= 1'b1;
          result_q    <= alu_res;
          overflow_q  <= alu_ovf;
          sign_q      <= alu_sign;
        end
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.sign      = sign_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset;
  int   ncomp = 0;
  int   nfail = 0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference computed from integer values, not from bit-level structure.
  function automatic void model(input int fn, input int a, input int b,
                                output int res, output int ovf, output int sgn);
    int sa, sb, s, w, sw;
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    res = 0; ovf = 0; sgn = 0;
    case (fn)
      0: res = a;
      1: res = b;
      3: begin res = (a - b + 256) % 256; ovf = (a < b) ? 1 : 0; end
      4: res = a % 3;
      10, 11: begin
        s   = (fn == 10) ? sa + sb : sa - sb;
        w   = (s + 512) % 256;
        sw  = (w >= 128) ? w - 256 : w;
        ovf = (s != sw) ? 1 : 0;
        sgn = (sw < 0) ? 1 : 0;
        res = (sw < 0) ? -sw : sw;
      end
      12: begin
        res = ((sa < 0) ? -sa : sa) % 3;
        sgn = (sa < 0 && res != 0) ? 1 : 0;
      end
      default: begin s = a + b; res = s % 256; ovf = (s > 255) ? 1 : 0; end
    endcase
  endfunction

  task automatic run_op(input int fn, input int a, input int b, input string tag);
    int res, ovf, sgn, lat, exp_lat;
    model(fn, a, b, res, ovf, sgn);
    exp_lat = (fn == 4 || fn == 12) ? 9 : 1;
    bus.FN = 4'(fn); bus.A = 8'(a); bus.B = 8'(b); bus.in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, 32'(bus.result), 32'(res));
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(ovf));
    check({tag, "_sign"}, 32'(bus.sign), 32'(sgn));
    @(posedge clk); #1;
  endtask

  initial begin
    int res, ovf, sgn, seen;
    reset = 1'b1;
    bus.A = '0; bus.B = '0; bus.FN = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_sign", 32'(bus.sign), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(2, 200, 100, "add_carry");
    run_op(10, 100, 50, "sadd_ovf");
    run_op(11, 5, 12, "ssub_neg");
    run_op(12, 'hF9, 0, "smod3");
    run_op(4, 'hF9, 0, "umod3");
    run_op(7, 3, 4, "fn_alias");
    run_op(11, 0, 128, "ssub_minneg");
    run_op(10, 128, 0, "sadd_mostneg");

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    bus.FN = 4'd2; bus.A = 8'd10; bus.B = 8'd20; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.FN = 4'd3; bus.A = 8'd5; bus.B = 8'd9;
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 32'(bus.out_valid), 1);
      check("hold_result", 32'(bus.result), 30);
      check("hold_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b_out_valid", 32'(bus.out_valid), 1);
    check("b2b_result", 32'(bus.result), 252);
    check("b2b_overflow", 32'(bus.overflow), 1);
    @(posedge clk); #1;

    // Reset in the middle of a mod-3 calculation.
    bus.FN = 4'd12; bus.A = 8'h85; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("calc_in_ready", 32'(bus.in_ready), 0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_in_ready", 32'(bus.in_ready), 1);
    check("abort_out_valid", 32'(bus.out_valid), 0);
    check("abort_result", 32'(bus.result), 0);
    check("abort_sign", 32'(bus.sign), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1;
    end
    check("abort_no_result", 32'(seen), 0);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
